// File: rtl/matu_pkg.sv
// matu_pkg: shared tile geometry for the matrix-unit feeder (tile length, field enum, position decode).
package matu_pkg;

    typedef enum logic [1:0] {FLD_A, FLD_B, FLD_D} field_e;

    typedef struct packed {
        field_e      fld;
        logic [15:0] row;
        logic [15:0] col;
    } elem_pos_t;

    function automatic int tile_len(input int ar, input int ac, input int br, input int bc);
        return ar * ac + br * bc + br;
    endfunction

    // Stream order is A row-major, then B row-major, then D by index.
    function automatic elem_pos_t map_pos(input int p, input int ar, input int ac, input int br, input int bc);
        elem_pos_t m;
        int q;
        m = '0;
        if (p < ar * ac) begin
            m.fld = FLD_A;
            m.row = 16'(p / ac);
            m.col = 16'(p % ac);
        end else if (p < ar * ac + br * bc) begin
            q     = p - ar * ac;
            m.fld = FLD_B;
            m.row = 16'(q / bc);
            m.col = 16'(q % bc);
        end else begin
            m.fld = FLD_D;
            m.row = 16'(p - ar * ac - br * bc);
            m.col = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/matu_feeder_bank.sv
// feeder_bank: one tile of element storage, written by linear position, read as parallel A/B/D.
module feeder_bank
    import matu_pkg::*;
#(
    parameter int  INA_ROWS = 3,
    parameter int  INA_COLS = 9,
    parameter int  INB_ROWS = 1,
    parameter int  INB_COLS = 9,
    parameter int  IN_WIDTH = 8,
    localparam int TILE_LEN = tile_len(INA_ROWS, INA_COLS, INB_ROWS, INB_COLS),
    localparam int PW       = $clog2(TILE_LEN)
) (
    input  logic                                         i_clk,
    input  logic                                         we,
    input  logic [PW-1:0]                                pos,
    input  logic [IN_WIDTH-1:0]                          data,
    output logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] a,
    output logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] b,
    output logic [INB_ROWS-1:0][IN_WIDTH-1:0]            d
);

    logic [IN_WIDTH-1:0] mem [TILE_LEN];

    always_ff @(posedge i_clk) begin
        if (we) mem[pos] <= data;
    end

    for (genvar p = 0; p < TILE_LEN; p++) begin : g_map
        localparam elem_pos_t M = map_pos(p, INA_ROWS, INA_COLS, INB_ROWS, INB_COLS);
        if (M.fld == FLD_A) begin : g_a
            assign a[M.row][M.col] = mem[p];
        end else if (M.fld == FLD_B) begin : g_b
            assign b[M.row][M.col] = mem[p];
        end else begin : g_d
            assign d[M.row] = mem[p];
        end
    end

endmodule

// File: rtl/matu_feeder.sv
// matu_feeder: assembles word-serial elements into ping-pong tile banks and presents whole tiles to the matrix unit.
module matu_feeder
    import matu_pkg::*;
#(
    parameter int INA_ROWS = 3,
    parameter int INA_COLS = 9,
    parameter int INB_ROWS = 1,
    parameter int INB_COLS = 9,
    parameter int IN_WIDTH = 8
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_pre_valid,
    output logic                                         o_pre_ready,
    input  logic [IN_WIDTH-1:0]                          i_data,
    input  logic                                         i_last,
    output logic                                         o_post_valid,
    input  logic                                         i_post_ready,
    output logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] o_a,
    output logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] o_b,
    output logic [INB_ROWS-1:0][IN_WIDTH-1:0]            o_d,
    output logic                                         o_err
);

    localparam int            TILE_LEN = tile_len(INA_ROWS, INA_COLS, INB_ROWS, INB_COLS);
    localparam int            PW       = $clog2(TILE_LEN);
    localparam logic [PW-1:0] LAST_POS = PW'(TILE_LEN - 1);

    typedef logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] a_t;
    typedef logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] b_t;
    typedef logic [INB_ROWS-1:0][IN_WIDTH-1:0]               d_t;

    a_t            bank_a [2];
    b_t            bank_b [2];
    d_t            bank_d [2];
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [PW-1:0] cnt;
    logic          accept;
    logic          drain;
    logic          at_last;

    assign o_pre_ready  = !full[wr_sel];
    assign o_post_valid = full[rd_sel];
    assign accept       = i_pre_valid && o_pre_ready;
    assign drain        = o_post_valid && i_post_ready;
    assign at_last      = cnt == LAST_POS;

    // Fill and drain always target different banks, so both updates to full can land in one cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
            o_err  <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= at_last ? '0 : cnt + 1'b1;
                if (at_last) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                end
                if (i_last != at_last) o_err <= 1'b1;
            end
            if (drain) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        feeder_bank #(
            .INA_ROWS(INA_ROWS),
            .INA_COLS(INA_COLS),
            .INB_ROWS(INB_ROWS),
            .INB_COLS(INB_COLS),
            .IN_WIDTH(IN_WIDTH)
        ) u_bank (
            .i_clk(i_clk),
            .we   (accept && (wr_sel == 1'(k))),
            .pos  (cnt),
            .data (i_data),
            .a    (bank_a[k]),
            .b    (bank_b[k]),
            .d    (bank_d[k])
        );
    end

    assign o_a = o_post_valid ? bank_a[rd_sel] : '0;
    assign o_b = o_post_valid ? bank_b[rd_sel] : '0;
    assign o_d = o_post_valid ? bank_d[rd_sel] : '0;

endmodule
